scene_loader: RTL and testbench

- Upstream feeder of the scene buffer.
- Accepts a byte stream from the UART receiver, parses a framed scene packet, and assembles bytes into object words.
- Issues one-cycle flash writes (wen/idx/data) into the scene buffer's write port.
- Commits the new object count (num_objs) only when the whole packet arrives with a valid checksum. Scenes can be reprogrammed at runtime without halting the renderer.

---
 rtl/scene_loader.sv | 150 +++++++++++++++
 tb/tb_scene_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/scene_loader.sv
// scene_loader: parses framed scene packets from the UART byte stream,
// assembles object words LSB byte first, writes each finished object to the
// scene buffer, and commits the new object count only after a good checksum.
module scene_loader #(
  parameter int OBJ_WIDTH      = 384,
  parameter int OBJ_IDX_WIDTH  = 8,
  parameter int MAX_NUM_OBJS   = 128,
  parameter int INIT_NUM_OBJS  = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     flash_obj_wen,
  output logic [OBJ_IDX_WIDTH-1:0] flash_obj_idx,
  output logic [OBJ_WIDTH-1:0]     flash_obj_data,
  output logic [OBJ_IDX_WIDTH-1:0] num_objs,
  output logic                     busy,
  output logic                     load_done,
  output logic                     load_err
);

  localparam int OBJ_BYTES = (OBJ_WIDTH + 7) / 8;
  localparam int SH_W      = OBJ_BYTES * 8;
  localparam int BC_W      = (OBJ_BYTES > 1) ? $clog2(OBJ_BYTES) : 1;
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BC_W-1:0] BC_LAST = BC_W'(OBJ_BYTES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      SYNC    = 8'hA5;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DATA, S_CHECK} state_t;

  state_t                   state_q;
  logic [OBJ_IDX_WIDTH-1:0] n_q;
  logic [OBJ_IDX_WIDTH-1:0] obj_idx_q;
  logic [BC_W-1:0]          byte_cnt_q;
  logic [7:0]               chk_q;
  logic [TO_W-1:0]          to_cnt_q;
  logic [SH_W-1:0]          shreg_q;
  logic [SH_W-1:0]          word_d;
  logic                     wen_q;
  logic [OBJ_IDX_WIDTH-1:0] idx_q;
  logic [OBJ_WIDTH-1:0]     data_q;
  logic [OBJ_IDX_WIDTH-1:0] num_objs_q;
  logic                     done_q;
  logic                     err_q;

  // Current object word with the incoming byte dropped into its lane, so the
  // final byte can be written out without waiting a cycle for the shift reg.
  always_comb begin
    word_d = shreg_q;
    word_d[8*int'(byte_cnt_q) +: 8] = rx_data;
  end

  // Packet parser FSM, write port register, commit and timeout handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      obj_idx_q  <= '0;
      byte_cnt_q <= '0;
      chk_q      <= '0;
      to_cnt_q   <= '0;
      shreg_q    <= '0;
      wen_q      <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      num_objs_q <= OBJ_IDX_WIDTH'(INIT_NUM_OBJS);
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wen_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;

      // Idle time is only measured while a packet is in flight.
      if (state_q == S_IDLE || rx_valid) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end

      if (rx_valid) begin
        case (state_q)
          S_IDLE: begin
            if (rx_data == SYNC) begin
              state_q <= S_COUNT;
            end
          end
          S_COUNT: begin
            if (rx_data == 8'd0 || int'(rx_data) > MAX_NUM_OBJS) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              n_q        <= OBJ_IDX_WIDTH'(rx_data);
              obj_idx_q  <= '0;
              byte_cnt_q <= '0;
              chk_q      <= rx_data;
              state_q    <= S_DATA;
            end
          end
          S_DATA: begin
            // A sync value here is just payload.
            shreg_q <= word_d;
            chk_q   <= chk_q ^ rx_data;
            if (byte_cnt_q == BC_LAST) begin
              byte_cnt_q <= '0;
              wen_q      <= 1'b1;
              idx_q      <= obj_idx_q;
              data_q     <= word_d[OBJ_WIDTH-1:0];
              obj_idx_q  <= obj_idx_q + 1'b1;
              if (obj_idx_q == n_q - 1'b1) begin
                state_q <= S_CHECK;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
          S_CHECK: begin
            if (rx_data == chk_q) begin
              num_objs_q <= n_q;
              done_q     <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE && to_cnt_q == TO_LAST) begin
        err_q      <= 1'b1;
        state_q    <= S_IDLE;
        byte_cnt_q <= '0;
        obj_idx_q  <= '0;
        chk_q      <= '0;
      end
    end
  end

  assign flash_obj_wen  = wen_q;
  assign flash_obj_idx  = idx_q;
  assign flash_obj_data = data_q;
  assign num_objs       = num_objs_q;
  assign busy           = (state_q != S_IDLE);
  assign load_done      = done_q;
  assign load_err       = err_q;

endmodule

// File: tb/tb_scene_loader.sv
// Directed bench for scene_loader with 20-bit objects (3 bytes each) and a
// 50-cycle timeout. Expected writes and done/err pulses go into queues when
// the bytes are driven and are matched when the DUT produces them.
module tb_scene_loader;

  localparam int OW = 20;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          flash_obj_wen;
  logic [IW-1:0] flash_obj_idx;
  logic [OW-1:0] flash_obj_data;
  logic [IW-1:0] num_objs;
  logic          busy;
  logic          load_done;
  logic          load_err;

  scene_loader #(
    .OBJ_WIDTH(OW), .OBJ_IDX_WIDTH(IW), .MAX_NUM_OBJS(128),
    .INIT_NUM_OBJS(1), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .flash_obj_wen(flash_obj_wen), .flash_obj_idx(flash_obj_idx),
    .flash_obj_data(flash_obj_data), .num_objs(num_objs), .busy(busy),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [OW-1:0] data; int cyc; } wr_t;
  typedef struct { logic [1:0] kind; int cyc; } ev_t;

  localparam logic [1:0] K_DONE = 2'b10;
  localparam logic [1:0] K_ERR  = 2'b01;
  localparam logic [1:0] K_NONE = 2'b00;

  wr_t        wq[$];
  ev_t        eq[$];
  logic [7:0] pkt[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every write and every done/err pulse must be expected.
  always @(negedge clk) begin
    if (!rst) begin
      if (flash_obj_wen) begin
        check("wen_expected", 64'(wq.size() > 0), 64'd1);
        if (wq.size() > 0) begin
          wr_t w;
          w = wq.pop_front();
          check("wr_idx", 64'(flash_obj_idx), 64'(w.idx));
          check("wr_data", 64'(flash_obj_data), 64'(w.data));
          check("wr_cycle", 64'(cyc), 64'(w.cyc));
        end
      end
      if (load_done || load_err) begin
        check("ev_expected", 64'(eq.size() > 0), 64'd1);
        if (eq.size() > 0) begin
          ev_t e;
          e = eq.pop_front();
          check("ev_kind", 64'({load_done, load_err}), 64'(e.kind));
          check("ev_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    check("rst_wen", 64'(flash_obj_wen), 64'd0);
    check("rst_idx", 64'(flash_obj_idx), 64'd0);
    check("rst_data", 64'(flash_obj_data), 64'd0);
    check("rst_num_objs", 64'(num_objs), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done_err", 64'({load_done, load_err}), 64'd0);
    rst = 1'b0;
  endtask

  task automatic add_chk(input logic [7:0] corrupt);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < pkt.size(); i++) x = x ^ pkt[i];
    pkt.push_back(x ^ corrupt);
  endtask

  // Drives pkt with `gap` idle cycles after each byte and records what the
  // loader must produce: a write one cycle after each object's third byte,
  // and `last_kind` one cycle after the final byte.
  task automatic send_pkt(input int gap, input logic [1:0] last_kind);
    int n;
    logic [23:0] w;
    n = (pkt.size() > 1) ? int'(pkt[1]) : 0;
    for (int i = 0; i < pkt.size(); i++) begin
      @(negedge clk);
      rx_data = pkt[i]; rx_valid = 1'b1; last_cyc = cyc;
      if (i >= 2 && i < 2 + 3 * n && (i - 2) % 3 == 2) begin
        w = {pkt[i], pkt[i-1], pkt[i-2]};
        wq.push_back('{(i - 2) / 3, w[OW-1:0], cyc + 1});
      end
      if (i == pkt.size() - 1 && last_kind != K_NONE) eq.push_back('{last_kind, cyc + 1});
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); rx_valid = 1'b0;
      end
    end
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic settle(input string tag, input int n_exp);
    repeat (5) @(negedge clk);
    check({tag, "_wq_empty"}, 64'(wq.size()), 64'd0);
    check({tag, "_eq_empty"}, 64'(eq.size()), 64'd0);
    check({tag, "_num_objs"}, 64'(num_objs), 64'(n_exp));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    wq.delete(); eq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Nominal packet, bytes spaced two idle cycles apart.
    pkt = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    add_chk(8'h00);
    send_pkt(2, K_DONE);
    settle("nominal", 2);

    // Same packet with back-to-back strobes.
    do_reset();
    pkt = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    add_chk(8'h00);
    send_pkt(0, K_DONE);
    settle("b2b", 2);

    // Sync value inside the payload is data; top bits of last byte dropped.
    do_reset();
    pkt = '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hF7};
    add_chk(8'h00);
    send_pkt(0, K_DONE);
    settle("sync_in_data", 1);

    // Bad checksum: writes happen, count is not committed.
    do_reset();
    pkt = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    add_chk(8'h01);
    send_pkt(1, K_ERR);
    settle("bad_chk", 1);

    // Zero and oversized counts are rejected immediately; noise before sync ignored.
    pkt = '{8'h3C, 8'h00, 8'hA5, 8'h00};
    send_pkt(0, K_ERR);
    settle("count_zero", 1);
    pkt = '{8'hA5, 8'd129};
    send_pkt(0, K_ERR);
    settle("count_big", 1);

    // Timeout 50 cycles after the last strobe, then a clean load.
    pkt = '{8'hA5, 8'h01, 8'h11};
    send_pkt(0, K_NONE);
    eq.push_back('{K_ERR, last_cyc + 51});
    for (int k = 0; k < 100 && cyc < last_cyc + 50; k++) @(negedge clk);
    check("to_busy_before", 64'(busy), 64'd1);
    @(negedge clk);
    check("to_busy_after", 64'(busy), 64'd0);
    settle("timeout", 1);
    pkt = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    add_chk(8'h00);
    send_pkt(0, K_DONE);
    settle("after_timeout", 2);

    // Reset in the middle of a packet drops it silently.
    do_reset();
    pkt = '{8'hA5, 8'h02, 8'h11};
    send_pkt(0, K_NONE);
    check("mid_busy", 64'(busy), 64'd1);
    do_reset();
    settle("mid_reset", 1);
    pkt = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    add_chk(8'h00);
    send_pkt(0, K_DONE);
    settle("after_reset", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
